// File: rtl/ovl_memory_arbiter_pkg.sv
// Shared types and limits for the round-robin memory arbiter.
// Holds the FSM state encodings and the parameter ceilings.
package ovl_memory_arbiter_pkg;

    localparam int MAX_NUM_REQ      = 8;
    localparam int MAX_READ_LATENCY = 4;
    localparam int CNT_W            = $clog2(MAX_READ_LATENCY);

    typedef enum logic {
        OVL_MARB_IDLE  = 1'b0,
        OVL_MARB_RWAIT = 1'b1
    } marb_state_e;

endpackage

// File: rtl/ovl_rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at ptr and wraps, so the first asserted request at or after ptr wins.
module ovl_rr_arbiter #(
    parameter int num_req = 4,
    localparam int IW     = $clog2(num_req)
) (
    input  logic [num_req-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [num_req-1:0] win_onehot,
    output logic [IW-1:0]      win_idx
);

    logic found;
    int   cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = 0;
        for (int off = 0; off < num_req; off++) begin
            cand = (int'(ptr) + off) % num_req;
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ovl_memory_arbiter.sv
// Round-robin controller sharing one memory port among num_req requesters,
// with per-request address range checking and a single outstanding read.
//
// state          | meaning
// OVL_MARB_IDLE  | arbitrate; writes and range errors complete here in one cycle
// OVL_MARB_RWAIT | read outstanding; count down to rdata capture, no grants until count==0
module ovl_memory_arbiter
    import ovl_memory_arbiter_pkg::*;
#(
    parameter int num_req      = 4,
    parameter int data_width   = 8,
    parameter int addr_width   = 4,
    parameter int read_latency = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [addr_width-1:0]         start_addr,
    input  logic [addr_width-1:0]         end_addr,
    input  logic [num_req-1:0]            req_valid,
    input  logic [num_req-1:0]            req_write,
    input  logic [num_req*addr_width-1:0] req_addr,
    input  logic [num_req*data_width-1:0] req_wdata,
    output logic [num_req-1:0]            gnt,
    output logic [num_req-1:0]            rsp_valid,
    output logic [num_req-1:0]            rsp_err,
    output logic [data_width-1:0]         rsp_rdata,
    output logic                          ren,
    output logic                          wen,
    output logic [addr_width-1:0]         raddr,
    output logic [addr_width-1:0]         waddr,
    output logic [data_width-1:0]         wdata,
    input  logic [data_width-1:0]         rdata
);

    localparam int IW = $clog2(num_req);

    marb_state_e           state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [num_req-1:0]    win_onehot;
    logic [IW-1:0]         win_idx;
    logic [addr_width-1:0] win_addr;
    logic [data_width-1:0] win_wdata;
    logic                  win_write;
    logic                  in_range;
    logic                  arb_ok;

    logic [num_req-1:0]    gnt_d, rsp_valid_d, rsp_err_d;
    logic [data_width-1:0] rsp_rdata_d, wdata_d;
    logic [addr_width-1:0] raddr_d, waddr_d;
    logic                  ren_d, wen_d;

    ovl_rr_arbiter #(.num_req(num_req)) u_rr (
        .req        (req_valid),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    assign win_addr  = req_addr[int'(win_idx)*addr_width +: addr_width];
    assign win_wdata = req_wdata[int'(win_idx)*data_width +: data_width];
    assign win_write = req_write[win_idx];
    // start_addr > end_addr makes this false for every address
    assign in_range  = (win_addr >= start_addr) && (win_addr <= end_addr);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_err_d   = '0;
        rsp_rdata_d = rsp_rdata;
        ren_d       = 1'b0;
        wen_d       = 1'b0;
        raddr_d     = raddr;
        waddr_d     = waddr;
        wdata_d     = wdata;
        arb_ok      = 1'b0;

        case (state_q)
            OVL_MARB_IDLE: arb_ok = 1'b1;
            OVL_MARB_RWAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d          = rdata;
                    state_d              = OVL_MARB_IDLE;
                    arb_ok               = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = OVL_MARB_IDLE;
        endcase

        if (arb_ok && enable && (|req_valid)) begin
            gnt_d = win_onehot;
            ptr_d = (win_idx == IW'(num_req - 1)) ? '0 : win_idx + 1'b1;
            if (!in_range) begin
                rsp_err_d = win_onehot;
            end else if (win_write) begin
                wen_d   = 1'b1;
                waddr_d = win_addr;
                wdata_d = win_wdata;
            end else begin
                ren_d   = 1'b1;
                raddr_d = win_addr;
                owner_d = win_idx;
                cnt_d   = CNT_W'(read_latency - 1);
                state_d = OVL_MARB_RWAIT;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= OVL_MARB_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= '0;
            rsp_rdata <= '0;
            ren       <= 1'b0;
            wen       <= 1'b0;
            raddr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            ren       <= ren_d;
            wen       <= wen_d;
            raddr     <= raddr_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_ovl_memory_arbiter.sv
// Directed bench for ovl_memory_arbiter with read_latency=2 and four requesters.
module tb_ovl_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  start_addr, end_addr;
    logic [3:0]  req_valid, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt, rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata, wdata, rdata;
    logic        ren, wen;
    logic [3:0]  raddr, waddr;

    int errors = 0;
    int checks = 0;

    ovl_memory_arbiter #(
        .num_req(4), .data_width(8), .addr_width(4), .read_latency(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .start_addr(start_addr), .end_addr(end_addr),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .ren(ren), .wen(wen), .raddr(raddr), .waddr(waddr), .wdata(wdata),
        .rdata(rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [3:0] a, input logic [7:0] d);
        req_valid[i]       = 1'b1;
        req_write[i]       = wr;
        req_addr[i*4 +: 4] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; start_addr = 4'd0; end_addr = 4'd15;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; rdata = '0;
        step(); step();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_strobes", {30'd0, ren, wen}, 32'h0);
        chk("rst_rsp", {24'd0, rsp_valid, rsp_err}, 32'h0);
        reset = 1'b1; enable = 1'b1;

        // single write
        set_req(0, 1'b1, 4'd3, 8'hA5);
        step();
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_strobes", {30'd0, ren, wen}, 32'h1);
        chk("wr_waddr", 32'(waddr), 32'h3);
        chk("wr_wdata", 32'(wdata), 32'hA5);
        req_valid = '0;
        step();
        chk("wr_idle_gnt", {28'd0, gnt}, 32'h0);
        chk("wr_idle_wen", 32'(wen), 32'h0);

        // read, latency 2, with a write waiting behind it
        set_req(1, 1'b0, 4'd5, 8'h00);
        step();
        chk("rd_gnt", 32'(gnt), 32'h2);
        chk("rd_strobes", {30'd0, ren, wen}, 32'h2);
        chk("rd_raddr", 32'(raddr), 32'h5);
        req_valid = '0;
        set_req(0, 1'b1, 4'd2, 8'h77);
        step();
        chk("rwait_gnt", 32'(gnt), 32'h0);
        chk("rwait_strobes", {30'd0, ren, wen}, 32'h0);
        chk("rwait_rsp", 32'(rsp_valid), 32'h0);
        rdata = 8'h3C;
        step();
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
        chk("rd_same_cycle_gnt", 32'(gnt), 32'h1);
        chk("rd_same_cycle_wen", {30'd0, ren, wen}, 32'h1);
        chk("rd_same_cycle_waddr", 32'(waddr), 32'h2);
        req_valid = '0; rdata = 8'h00;
        step();
        chk("rd_done_rsp", 32'(rsp_valid), 32'h0);
        chk("rd_done_gnt", 32'(gnt), 32'h0);

        // reset in the middle of a read
        set_req(2, 1'b0, 4'd7, 8'h00);
        step();
        chk("rr_ren", 32'(ren), 32'h1);
        chk("rr_gnt", 32'(gnt), 32'h4);
        req_valid = '0; rdata = 8'h55;
        step();
        reset = 1'b0;
        #1;
        chk("rr_async_outs", {20'd0, gnt, rsp_valid, 2'd0, ren, wen}, 32'h0);
        chk("rr_async_raddr", 32'(raddr), 32'h0);
        step();
        reset = 1'b1;
        step();
        chk("rr_no_rsp0", 32'(rsp_valid), 32'h0);
        step();
        chk("rr_no_rsp1", 32'(rsp_valid), 32'h0);
        chk("rr_rdata_clear", 32'(rsp_rdata), 32'h0);
        rdata = 8'h00;

        // fairness: everyone holds a write, pointer starts at 0 after reset
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), 8'(8'h10 + i));
        step();
        chk("rr_gnt0", 32'(gnt), 32'h1);
        chk("rr_waddr0", 32'(waddr), 32'h1);
        step();
        chk("rr_gnt1", 32'(gnt), 32'h2);
        chk("rr_wdata1", 32'(wdata), 32'h11);
        step();
        chk("rr_gnt2", 32'(gnt), 32'h4);
        step();
        chk("rr_gnt3", 32'(gnt), 32'h8);
        chk("rr_waddr3", 32'(waddr), 32'h4);
        step();
        chk("rr_gnt4", 32'(gnt), 32'h1);
        req_valid = '0;
        step();
        chk("rr_gnt_idle", 32'(gnt), 32'h0);

        // range checks; pointer is now 1
        start_addr = 4'd4; end_addr = 4'd10;
        set_req(2, 1'b0, 4'd11, 8'h00);
        step();
        chk("err_gnt", 32'(gnt), 32'h4);
        chk("err_rsp_err", 32'(rsp_err), 32'h4);
        chk("err_strobes", {30'd0, ren, wen}, 32'h0);
        req_valid = '0;
        set_req(3, 1'b1, 4'd4, 8'hC4);
        step();
        chk("lo_edge_gnt", 32'(gnt), 32'h8);
        chk("lo_edge_err", 32'(rsp_err), 32'h0);
        chk("lo_edge_wen", {30'd0, ren, wen}, 32'h1);
        chk("lo_edge_waddr", 32'(waddr), 32'h4);
        req_valid = '0;
        set_req(0, 1'b1, 4'd10, 8'hCA);
        step();
        chk("hi_edge_gnt", 32'(gnt), 32'h1);
        chk("hi_edge_wen", {30'd0, ren, wen}, 32'h1);
        chk("hi_edge_waddr", 32'(waddr), 32'hA);
        req_valid = '0;
        start_addr = 4'd9; end_addr = 4'd3;
        set_req(1, 1'b1, 4'd5, 8'h00);
        step();
        chk("inv_range_err", 32'(rsp_err), 32'h2);
        chk("inv_range_wen", {30'd0, ren, wen}, 32'h0);
        req_valid = '0;
        start_addr = 4'd0; end_addr = 4'd15;

        // enable held low with a pending request
        enable = 1'b0;
        set_req(3, 1'b1, 4'd6, 8'h66);
        step();
        chk("en_lo_gnt0", 32'(gnt), 32'h0);
        step();
        chk("en_lo_gnt1", 32'(gnt), 32'h0);
        chk("en_lo_wen", 32'(wen), 32'h0);
        enable = 1'b1;
        step();
        chk("en_hi_gnt", 32'(gnt), 32'h8);
        chk("en_hi_waddr", 32'(waddr), 32'h6);
        chk("en_hi_wdata", 32'(wdata), 32'h66);
        req_valid = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
